data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Two-master arbiter that shares the single-port `data_ram` between the CPU load/store port (master 0) and a secondary bus master such as a DMA or debug loader (master 1). It sits in the SOPC between the core's `ram_*` outputs and `data_ram`. Arbitration is fixed-priority to master 0, with a starvation counter that guarantees master 1 progress. Master 1 may also lock the RAM for atomic bursts. Read data is steered back to whichever master issued the read.

## Interface
- `ADDR_W`, 32: address width (matches the global address bus).
- `DATA_W`, 32: data width (matches the global data bus).
- `STARVE_MAX`, 4: number of consecutive denied master-1 request cycles that forces a master-1 grant. Legal range 1..15.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `m0_req`, `m1_req`  in  1  access request.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_sel`, `m1_sel`  in  4  byte write enables.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m1_lock`  in  1  hold the grant after this access (burst lock).
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered).
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data.
- `ram_en`, `ram_write_en`  out  1  to `data_ram`.
- `ram_write_sel`  out  4  to `data_ram`.
- `ram_addr`  out  ADDR_W  to `data_ram`.
- `ram_write_data`  out  DATA_W  to `data_ram`.
- `ram_read_data`  in  DATA_W  from `data_ram`; valid one cycle after `ram_en` with `ram_write_en` = 0.

## Operation
- States: OPEN and LOCK_M1.
- **OPEN, grant rules:**
  - Only one master requesting: that master is granted.
  - Both requesting: master 0 is granted, unless `starve_cnt` == STARVE_MAX, in which case master 1 is granted.
- **LOCK_M1:**
  - Only master 1 can be granted; `m0_gnt` = 0.
  - The state is left, back to OPEN, after a master-1 grant with `m1_lock` = 0, or after any cycle with `m1_req` = 0.
- **Entering the lock:** OPEN → LOCK_M1 when master 1 is granted with `m1_lock` = 1.
- **Starvation counter:**
  - `starve_cnt` increments, saturating at STARVE_MAX, on every cycle where `m1_req` = 1 and `m1_gnt` = 0.
  - It clears on a master-1 grant or when `m1_req` = 0.
- **RAM muxing:**
  - The granted master's `we`, `sel`, `addr` and `wdata` drive the `ram_*` outputs, with `ram_en` = 1.
  - With no grant: `ram_en` = 0, `ram_write_en` = 0, and the other `ram_*` outputs are 0.
- **Read return:**
  - An accepted read registers the owner index.
  - The next cycle, the owner's `rvalid` = 1 and its `rdata` = `ram_read_data`.
  - The non-owner's `rdata` = 0.
- **Writes:** no response; the access completes at the grant edge.
- **Reset (`rst` = 0 at a rising edge):**
  - state = OPEN, `starve_cnt` = 0, both `rvalid` = 0, both `rdata` = 0.
  - Any pending read return is discarded.
  - While `rst` = 0, all `gnt` = 0 and `ram_en` = 0.

## Timing
- Grant latency is 0 cycles; throughput is one access per cycle. Back-to-back accesses from either master, or alternating between masters, need no bubble.
- Read data latency is exactly 1 cycle after the accepting edge, i.e. the cycle where `req` & `gnt` = 1.
- Requests are not queued: a master holds `req` and its fields stable until it sees `gnt`.
- With `m0_req` held continuously and `m1_req` held, master 1 is granted at most STARVE_MAX+1 cycles after it first asserts `m1_req`.
- Dropping `m1_req` during LOCK_M1 returns the arbiter to OPEN on the next edge.
- A read issued in the same cycle the lock is released still returns normally.

## Structure
- The global define header holds:
  - `ADDR_BUS` / `DATA_BUS` widths;
  - master index encodings `ARB_M0` = 0, `ARB_M1` = 1;
  - state encodings `ARB_OPEN`, `ARB_LOCK_M1`.
- One sub-module, `arb_starve_cnt`: the saturating counter with inputs `inc`/`clr` and output `hit` (count == STARVE_MAX), parameterised by STARVE_MAX.
- The grant mux and the read-return register stay in `data_ram_arbiter`.

## Test plan
- **Reset:** drive `rst` = 0 for 2 cycles with both `req` = 1. Required: `gnt` = 00, `ram_en` = 0, `rvalid` = 00; first grant goes to master 0 in the cycle after `rst` rises.
- **Solo read:**
  - m1 reads 0x100 while RAM holds 0xDEADBEEF.
  - Required: `m1_gnt` = 1 the same cycle; the next cycle `m1_rvalid` = 1 and `m1_rdata` = 0xDEADBEEF, with `m0_rvalid` = 0.
- **Contention, STARVE_MAX = 4:**
  - Both masters request continuously.
  - Required grants: m0 ×4, then m1 ×1, then the pattern repeats.
  - `starve_cnt` returns to 0 after each m1 grant.
- **Lock burst:**
  - m1 writes 0x200..0x20C: `m1_lock` = 1 for the first 3 writes and 0 on the 4th; m0 requests throughout.
  - Required: `m0_gnt` = 0 for those 4 cycles and `m0_gnt` = 1 on the 5th; RAM holds all 4 words.
- **Interleaved reads:**
  - m0 reads 0x0 then m1 reads 0x4 on consecutive cycles.
  - Required: `rvalid` pulses go to m0, then m1, each carrying its own data; no cross-steering.
- **Reset mid-read:** assert `rst` = 0 in the cycle after an m0 read is accepted. Required: `m0_rvalid` stays 0 and state = OPEN.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter_pkg
//   Shared definitions for the data_ram arbiter slice:
//     ADDR_BUS / DATA_BUS : global address / data bus widths
//     SEL_W               : byte-enable width of the data_ram port
//     CNT_W               : width of the starvation counter (STARVE_MAX <= 15)
//     ARB_M0 / ARB_M1     : master index encodings used for read steering
//     arb_state_e         : arbiter FSM state encodings
// ---------------------------------------------------------------------------
package data_ram_arbiter_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int SEL_W    = 4;
  localparam int CNT_W    = 4;

  // Master index encodings; a single bit is enough for two masters.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  typedef enum logic {
    ARB_OPEN    = 1'b0,
    ARB_LOCK_M1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/data_ram_arbiter_starve_cnt.sv
// ---------------------------------------------------------------------------
// arb_starve_cnt
//   Saturating starvation counter for master 1.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-low reset (count -> 0)
//     inc  in   master 1 requested and was denied this cycle
//     clr  in   master 1 was granted or is not requesting (wins over inc)
//     hit  out  count has reached STARVE_MAX (forces a master-1 grant)
//     cnt  out  current count, exposed for observation
//   STARVE_MAX must lie in 1..15 so that it fits the CNT_W-bit count.
// ---------------------------------------------------------------------------
module arb_starve_cnt
  import data_ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      // Saturate at MAX_C: once there, master 1 wins the next contended cycle.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == MAX_C);
  assign cnt = cnt_q;

endmodule

// File: rtl/data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter
//   Shares the single-port data_ram between the CPU load/store port (master 0)
//   and a secondary bus master such as DMA / debug loader (master 1).
//   Fixed priority to master 0, with a starvation counter guaranteeing master-1
//   progress, and a burst lock that lets master 1 keep the RAM across accesses.
//
//   Handshake: a master raises req with we/sel/addr/wdata stable and holds them
//   until it sees gnt in the same cycle; req & gnt in a cycle means the access
//   is accepted at the following rising edge. Writes complete at that edge.
//   Reads return exactly one cycle later as an rvalid pulse with rdata on the
//   issuing master only; there is no back-pressure on the read return.
//
//   Ports:
//     clk, rst                       clock, synchronous active-low reset
//     m0_* / m1_*  req,we,sel,addr,wdata   master request fields
//     m1_lock                        keep the RAM for master 1 after this access
//     m0_gnt, m1_gnt                 combinational grants
//     m0_rvalid, m1_rvalid           read data valid (registered)
//     m0_rdata, m1_rdata             read data, 0 unless that master's rvalid
//     ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data  to data_ram
//     ram_read_data                  from data_ram, one cycle after a read
//     dbg_state, dbg_starve_cnt      arbiter state and starvation count
// ---------------------------------------------------------------------------
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_BUS,
  parameter int DATA_W     = DATA_BUS,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: CPU load/store port
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1: secondary bus master
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // data_ram port
  output logic              ram_en,
  output logic              ram_write_en,
  output logic [SEL_W-1:0]  ram_write_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  // observation
  output arb_state_e        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  arb_state_e state_q;
  arb_state_e state_d;

  // Read-return tracking: one pending read at most, tagged with its owner.
  logic rd_pend_q;
  logic rd_pend_d;
  logic rd_owner_q;
  logic rd_owner_d;

  logic starve_hit;
  logic starve_inc;
  logic starve_clr;

  // -------------------------------------------------------------------------
  // Starvation counter
  // -------------------------------------------------------------------------
  assign starve_inc = m1_req & ~m1_gnt;
  assign starve_clr = ~m1_req | m1_gnt;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (starve_hit),
    .cnt (dbg_starve_cnt)
  );

  // -------------------------------------------------------------------------
  // Grant logic (combinational, zero-latency)
  // -------------------------------------------------------------------------
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    // No grants at all while reset is held, so nothing reaches the RAM.
    if (rst) begin
      unique case (state_q)
        ARB_OPEN: begin
          if (m0_req && m1_req) begin
            // Master 0 wins contention unless master 1 has been starved long enough.
            if (starve_hit) begin
              m1_gnt = 1'b1;
            end else begin
              m0_gnt = 1'b1;
            end
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        ARB_LOCK_M1: begin
          m1_gnt = m1_req;
        end
        default: begin
          m0_gnt = 1'b0;
          m1_gnt = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and read-return tracking
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_OPEN: begin
        if (m1_gnt && m1_lock) begin
          state_d = ARB_LOCK_M1;
        end
      end
      ARB_LOCK_M1: begin
        // Leave on an unlocked final access, or as soon as master 1 lets go of req.
        if (!m1_req || !m1_lock) begin
          state_d = ARB_OPEN;
        end
      end
      default: begin
        state_d = ARB_OPEN;
      end
    endcase
  end

  always_comb begin
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (m0_gnt && !m0_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = ARB_M0;
    end else if (m1_gnt && !m1_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = ARB_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_OPEN;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= ARB_M0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read return steering
  // -------------------------------------------------------------------------
  // A read accepted just before reset is asserted must not surface while
  // reset is held, so the registered pending flag is qualified by rst.
  assign m0_rvalid = rst & rd_pend_q & (rd_owner_q == ARB_M0);
  assign m1_rvalid = rst & rd_pend_q & (rd_owner_q == ARB_M1);
  assign m0_rdata  = m0_rvalid ? ram_read_data : '0;
  assign m1_rdata  = m1_rvalid ? ram_read_data : '0;

  // -------------------------------------------------------------------------
  // RAM port mux
  // -------------------------------------------------------------------------
  always_comb begin
    ram_en         = 1'b0;
    ram_write_en   = 1'b0;
    ram_write_sel  = '0;
    ram_addr       = '0;
    ram_write_data = '0;
    if (m0_gnt) begin
      ram_en         = 1'b1;
      ram_write_en   = m0_we;
      ram_write_sel  = m0_sel;
      ram_addr       = m0_addr;
      ram_write_data = m0_wdata;
    end else if (m1_gnt) begin
      ram_en         = 1'b1;
      ram_write_en   = m1_we;
      ram_write_sel  = m1_sel;
      ram_addr       = m1_addr;
      ram_write_data = m1_wdata;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_ram_arbiter
//   Directed bench for data_ram_arbiter with a small data_ram model. Read
//   expectations are queued when a read is accepted and retired when an
//   rvalid pulse appears.
// ---------------------------------------------------------------------------
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]    m0_sel;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]    m1_sel;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_en, ram_write_en;
  logic [3:0]    ram_write_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] ram_read_data = '0;
  arb_state_e    dbg_state;
  logic [3:0]    dbg_starve_cnt;

  data_ram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk), .rst (rst),
    .m0_req (m0_req), .m0_we (m0_we), .m0_sel (m0_sel), .m0_addr (m0_addr),
    .m0_wdata (m0_wdata), .m0_gnt (m0_gnt), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
    .m1_req (m1_req), .m1_we (m1_we), .m1_sel (m1_sel), .m1_addr (m1_addr),
    .m1_wdata (m1_wdata), .m1_lock (m1_lock), .m1_gnt (m1_gnt), .m1_rvalid (m1_rvalid),
    .m1_rdata (m1_rdata),
    .ram_en (ram_en), .ram_write_en (ram_write_en), .ram_write_sel (ram_write_sel),
    .ram_addr (ram_addr), .ram_write_data (ram_write_data), .ram_read_data (ram_read_data),
    .dbg_state (dbg_state), .dbg_starve_cnt (dbg_starve_cnt)
  );

  // -------------------------------------------------------------------------
  // data_ram model: registered read, byte-enabled write, preloaded once
  // -------------------------------------------------------------------------
  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h00] <= 32'h0A0A_0001;
      mem[8'h01] <= 32'h0B0B_0004;
      mem[8'h40] <= 32'hDEAD_BEEF;
      mem_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_write_en) begin
        for (int b = 0; b < 4; b++)
          if (ram_write_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_write_data[b*8 +: 8];
      end else begin
        ram_read_data <= mem[ram_addr[9:2]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checking and scoreboard
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {owner, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (m0_rvalid || m1_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_owner", {30'b0, m1_rvalid, m0_rvalid}, e[32] ? 32'h2 : 32'h1);
        chk("rdata_owner", e[32] ? m1_rdata : m0_rdata, e[31:0]);
        chk("rdata_other", e[32] ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_m0(input logic req, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    m1_req = req; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    logic exp_m1;

    // Reset held two cycles with both masters requesting reads
    rst = 1'b0;
    drive_m0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
      chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
      chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
      step();
    end
    rst = 1'b1;
    mid();
    chk("post_rst_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    chk("post_rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    chk("post_rst_state", 32'(dbg_state), 32'(ARB_OPEN));
    chk("post_rst_cnt", {28'b0, dbg_starve_cnt}, 32'h0);
    exp_q.push_back({ARB_M0, 32'h0A0A_0001});
    step();
    idle_all();
    mid();
    step();

    // Solo read by master 1
    drive_m1(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
    mid();
    chk("solo_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    chk("solo_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("solo_ram_addr", ram_addr, 32'h100);
    chk("solo_ram_we", {31'b0, ram_write_en}, 32'h0);
    exp_q.push_back({ARB_M1, 32'hDEAD_BEEF});
    step();
    idle_all();
    mid();
    chk("solo_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    step();

    // Contention: m0 x4 then m1 x1, repeating
    drive_m0(1'b1, 1'b1, 4'h3, 32'h40, 32'h1234_5678);
    drive_m1(1'b1, 1'b1, 4'hC, 32'h44, 32'h9ABC_DEF0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_m1 = ((i % (SMAX + 1)) == SMAX);
      mid();
      chk("cont_m0_gnt", {31'b0, m0_gnt}, exp_m1 ? 32'h0 : 32'h1);
      chk("cont_m1_gnt", {31'b0, m1_gnt}, exp_m1 ? 32'h1 : 32'h0);
      chk("cont_cnt", {28'b0, dbg_starve_cnt}, 32'(i % (SMAX + 1)));
      chk("cont_ram_addr", ram_addr, exp_m1 ? 32'h44 : 32'h40);
      chk("cont_ram_sel", {28'b0, ram_write_sel}, exp_m1 ? 32'hC : 32'h3);
      step();
    end
    idle_all();
    mid();
    chk("cont_cnt_clear", {28'b0, dbg_starve_cnt}, 32'h0);
    step();

    // Lock burst: m1 starved in, then holds the RAM for 4 writes
    drive_m0(1'b1, 1'b1, 4'hF, 32'h300, 32'h0000_0033);
    drive_m1(1'b1, 1'b1, 4'hF, 32'h200, 32'hA000_0000, 1'b1);
    for (int k = 0; k < SMAX; k++) begin
      mid();
      chk("lock_pre_m0_gnt", {31'b0, m0_gnt}, 32'h1);
      step();
    end
    mid();
    chk("lock_w0_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    chk("lock_w0_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    step();
    for (int w = 1; w < 4; w++) begin
      drive_m1(1'b1, 1'b1, 4'hF, 32'h200 + 32'(w * 4), 32'hA000_0000 + 32'(w), (w < 3));
      mid();
      chk("lock_state", 32'(dbg_state), 32'(ARB_LOCK_M1));
      chk("lock_m1_gnt", {31'b0, m1_gnt}, 32'h1);
      chk("lock_m0_gnt", {31'b0, m0_gnt}, 32'h0);
      step();
    end
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    chk("unlock_state", 32'(dbg_state), 32'(ARB_OPEN));
    chk("unlock_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    step();
    idle_all();
    for (int w = 0; w < 4; w++)
      chk("lock_mem", mem[8'h80 + 8'(w)], 32'hA000_0000 + 32'(w));

    // Read issued in the lock-release cycle still returns
    drive_m1(1'b1, 1'b1, 4'hF, 32'h210, 32'h5A5A_0001, 1'b1);
    mid();
    step();
    drive_m1(1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0);
    drive_m0(1'b1, 1'b1, 4'hF, 32'h300, 32'h0000_0044);
    mid();
    chk("rel_state", 32'(dbg_state), 32'(ARB_LOCK_M1));
    chk("rel_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    chk("rel_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    exp_q.push_back({ARB_M1, 32'hA000_0001});
    step();
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    chk("rel_open_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    step();

    // Dropping m1_req inside the lock returns to OPEN on the next edge
    idle_all();
    drive_m1(1'b1, 1'b1, 4'hF, 32'h214, 32'h5A5A_0002, 1'b1);
    mid();
    step();
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    drive_m0(1'b1, 1'b1, 4'hF, 32'h300, 32'h0000_0055);
    mid();
    chk("drop_state", 32'(dbg_state), 32'(ARB_LOCK_M1));
    chk("drop_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("drop_ram_en", {31'b0, ram_en}, 32'h0);
    step();
    mid();
    chk("drop_open", 32'(dbg_state), 32'(ARB_OPEN));
    chk("drop_m0_gnt_after", {31'b0, m0_gnt}, 32'h1);
    step();
    idle_all();

    // Interleaved reads, back to back
    drive_m0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    mid();
    chk("il_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    exp_q.push_back({ARB_M0, 32'h0A0A_0001});
    step();
    drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
    mid();
    chk("il_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    chk("il_m1_rvalid_early", {31'b0, m1_rvalid}, 32'h0);
    exp_q.push_back({ARB_M1, 32'h0B0B_0004});
    step();
    idle_all();
    mid();
    step();

    // Reset in the cycle after an accepted m0 read
    drive_m0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    mid();
    chk("rmr_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    step();
    idle_all();
    rst = 1'b0;
    mid();
    chk("rmr_rvalid_in_rst", {31'b0, m0_rvalid}, 32'h0);
    step();
    rst = 1'b1;
    mid();
    chk("rmr_rvalid_after", {31'b0, m0_rvalid}, 32'h0);
    chk("rmr_state", 32'(dbg_state), 32'(ARB_OPEN));
    step();

    mid();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
